// File: rtl/leaf_tx_scheduler.sv
// leaf_tx_scheduler: round-robin, credit-gated mux of user streams onto one registered BFT packet (user vld/ack in, dout_pkt/dout_ready out, cfg table + credit returns)
module leaf_tx_scheduler #(
  parameter int NUM_IN_PORTS = 4,
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int CREDIT_INIT = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int SEL_BITS = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1
) (
  input  logic                             clk_bft,
  input  logic                             reset_bft,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_IN_PORTS-1:0]          vld_user,
  output logic [NUM_IN_PORTS-1:0]          ack_user,
  input  logic [NUM_IN_PORTS-1:0]          credit_upd,
  input  logic                             cfg_we,
  input  logic [SEL_BITS-1:0]              cfg_sel,
  input  logic                             cfg_en,
  input  logic [NUM_LEAF_BITS-1:0]         cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]         cfg_port,
  output logic [PACKET_BITS-1:0]           dout_pkt,
  input  logic                             dout_ready,
  output logic [NUM_IN_PORTS*8-1:0]        credit_cnt_dbg
);
  logic en_tab [NUM_IN_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_tab [NUM_IN_PORTS];
  logic [NUM_PORT_BITS-1:0] port_tab [NUM_IN_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr [NUM_IN_PORTS];
  logic [7:0] credit [NUM_IN_PORTS];
  logic [7:0] cred_nxt [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0] elig;
  logic [SEL_BITS-1:0] rr_ptr, gnt_idx;
  logic gnt_vld, load;
  logic [PAYLOAD_BITS-1:0] din_sel;
  logic [9:0] sum;
  assign load = ~dout_pkt[PACKET_BITS-1] | dout_ready;
  always_comb begin
    elig = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    din_sel = '0;
    ack_user = '0;
    credit_cnt_dbg = '0;
    sum = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) elig[i] = vld_user[i] & en_tab[i] & (credit[i] != 8'd0);
    for (int k = NUM_IN_PORTS; k >= 1; k--)
      if (elig[(int'(rr_ptr) + k) % NUM_IN_PORTS]) begin
        gnt_idx = SEL_BITS'((int'(rr_ptr) + k) % NUM_IN_PORTS);
        gnt_vld = load & ~reset_bft;
      end
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      ack_user[i] = gnt_vld && gnt_idx == SEL_BITS'(i);
      din_sel |= ack_user[i] ? din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS] : '0;
      sum = 10'(credit[i]) + (credit_upd[i] ? 10'(FREESPACE_UPDATE_SIZE) : 10'd0) - {9'd0, ack_user[i]};
      cred_nxt[i] = sum > 10'(CREDIT_INIT) ? 8'(CREDIT_INIT) : sum[7:0];
      credit_cnt_dbg[i*8 +: 8] = credit[i];
    end
  end
  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      dout_pkt <= '0;
      rr_ptr <= SEL_BITS'(NUM_IN_PORTS - 1);
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        en_tab[i] <= 1'b0;
        leaf_tab[i] <= '0;
        port_tab[i] <= '0;
        addr[i] <= '0;
        credit[i] <= 8'(CREDIT_INIT);
      end
    end else begin
      if (load) dout_pkt <= gnt_vld ? {1'b1, leaf_tab[gnt_idx], port_tab[gnt_idx], addr[gnt_idx], din_sel} : '0;
      if (gnt_vld) begin
        rr_ptr <= gnt_idx;
        addr[gnt_idx] <= addr[gnt_idx] + 1'b1;
      end
      if (cfg_we) begin
        en_tab[cfg_sel] <= cfg_en;
        leaf_tab[cfg_sel] <= cfg_leaf;
        port_tab[cfg_sel] <= cfg_port;
      end
      for (int i = 0; i < NUM_IN_PORTS; i++) credit[i] <= cred_nxt[i];
    end
  end
endmodule

// File: tb/tb_leaf_tx_scheduler.sv
// tb_leaf_tx_scheduler: directed and randomized checks of leaf_tx_scheduler against a behavioural model
module tb_leaf_tx_scheduler;
  localparam int N = 4;
  logic clk_bft = 1'b0;
  logic reset_bft = 1'b1;
  logic [N*32-1:0] din_user = '0;
  logic [N-1:0] vld_user = '0;
  logic [N-1:0] ack_user;
  logic [N-1:0] credit_upd = '0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic cfg_en = 1'b0;
  logic [4:0] cfg_leaf = '0;
  logic [3:0] cfg_port = '0;
  logic [48:0] dout_pkt;
  logic dout_ready = 1'b1;
  logic [N*8-1:0] credit_cnt_dbg;
  int errors = 0;
  int checks = 0;
  int m_en[N], m_leaf[N], m_port[N], m_addr[N], m_cred[N];
  int m_rr = N - 1;
  int m_g = -1;
  logic [48:0] m_pkt = '0;
  logic [N-1:0] exp_ack;

  always #5 clk_bft = ~clk_bft;

  leaf_tx_scheduler dut (
    .clk_bft(clk_bft), .reset_bft(reset_bft), .din_user(din_user), .vld_user(vld_user),
    .ack_user(ack_user), .credit_upd(credit_upd), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_en(cfg_en), .cfg_leaf(cfg_leaf), .cfg_port(cfg_port), .dout_pkt(dout_pkt),
    .dout_ready(dout_ready), .credit_cnt_dbg(credit_cnt_dbg)
  );

  function automatic logic [N*8-1:0] exp_dbg();
    logic [N*8-1:0] r;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = 8'(m_cred[i]);
    return r;
  endfunction

  function automatic bit pkt_ok();
    return m_pkt[48] ? (dout_pkt === m_pkt) : (dout_pkt[48] === 1'b0);
  endfunction

  task automatic predict();
    exp_ack = '0;
    m_g = -1;
    if (!reset_bft && (!m_pkt[48] || dout_ready))
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (m_g < 0 && vld_user[j] && m_en[j] != 0 && m_cred[j] > 0) m_g = j;
      end
    if (m_g >= 0) exp_ack[m_g] = 1'b1;
  endtask

  task automatic advance();
    @(posedge clk_bft);
    if (reset_bft) begin
      m_pkt = '0;
      m_rr = N - 1;
      for (int i = 0; i < N; i++) begin
        m_en[i] = 0; m_leaf[i] = 0; m_port[i] = 0; m_addr[i] = 0; m_cred[i] = 128;
      end
    end else begin
      if (!m_pkt[48] || dout_ready)
        m_pkt = (m_g >= 0) ? {1'b1, 5'(m_leaf[m_g]), 4'(m_port[m_g]), 7'(m_addr[m_g]), din_user[m_g*32 +: 32]} : '0;
      for (int i = 0; i < N; i++) begin
        int c;
        c = m_cred[i] - ((m_g == i) ? 1 : 0) + (credit_upd[i] ? 64 : 0);
        m_cred[i] = (c > 128) ? 128 : c;
      end
      if (m_g >= 0) begin
        m_addr[m_g] = (m_addr[m_g] + 1) % 128;
        m_rr = m_g;
      end
      if (cfg_we) begin
        m_en[cfg_sel] = int'(cfg_en);
        m_leaf[cfg_sel] = int'(cfg_leaf);
        m_port[cfg_sel] = int'(cfg_port);
      end
    end
    #1;
  endtask

  task automatic cfg(input int sel, input int en, input int leaf, input int port);
    @(negedge clk_bft);
    vld_user = '0; credit_upd = '0; dout_ready = 1'b1;
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_en = 1'(en); cfg_leaf = 5'(leaf); cfg_port = 4'(port);
    #1; predict();
    advance();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_bft);
    reset_bft = 1'b1; vld_user = '0; credit_upd = '0; cfg_we = 1'b0; dout_ready = 1'b1;
    #1; predict();
    advance();
    @(negedge clk_bft);
    reset_bft = 1'b0;
  endtask

  task automatic test_reset();
    reset_bft = 1'b1;
    vld_user = '1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_bft);
      #1; predict();
      checks++;
      if (ack_user !== 4'b0000) begin errors++; $display("FAIL reset ack: got %b want 0000", ack_user); end
      advance();
      checks++;
      if (dout_pkt !== 49'd0) begin errors++; $display("FAIL reset pkt: got %h want 0", dout_pkt); end
      checks++;
      if (credit_cnt_dbg !== {4{8'd128}}) begin errors++; $display("FAIL reset credit: got %h want %h", credit_cnt_dbg, {4{8'd128}}); end
    end
    @(negedge clk_bft);
    reset_bft = 1'b0;
    vld_user = '0;
  endtask

  task automatic test_single_stream();
    cfg(1, 1, 5, 3);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      din_user[63:32] = 32'hDEADBEEF;
      vld_user = 4'b0010; dout_ready = 1'b1;
      #1; predict();
      checks++;
      if (ack_user !== 4'b0010) begin errors++; $display("FAIL single ack %0d: got %b want 0010", n, ack_user); end
      advance();
      checks++;
      if (dout_pkt !== {1'b1, 5'd5, 4'd3, 7'(n), 32'hDEADBEEF})
        begin errors++; $display("FAIL single pkt %0d: got %h want %h", n, dout_pkt, {1'b1, 5'd5, 4'd3, 7'(n), 32'hDEADBEEF}); end
    end
    vld_user = '0;
  endtask

  task automatic test_round_robin();
    int cnt[N];
    for (int i = 0; i < N; i++) begin
      cfg(i, 1, $urandom_range(31), $urandom_range(15));
      cnt[i] = 0;
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      vld_user = '1; dout_ready = 1'b1;
      #1; predict();
      checks++;
      if (ack_user !== exp_ack) begin errors++; $display("FAIL rr ack %0d: got %b want %b", n, ack_user, exp_ack); end
      for (int i = 0; i < N; i++) cnt[i] += int'(ack_user[i]);
      advance();
      checks++;
      if (!pkt_ok()) begin errors++; $display("FAIL rr pkt %0d: got %h want %h", n, dout_pkt, m_pkt); end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] != 2) begin errors++; $display("FAIL rr share %0d: got %0d want 2", i, cnt[i]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [48:0] held;
    held = dout_pkt;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      vld_user = '1; dout_ready = 1'b0;
      #1; predict();
      checks++;
      if (ack_user !== 4'b0000) begin errors++; $display("FAIL stall ack %0d: got %b want 0000", n, ack_user); end
      advance();
      checks++;
      if (dout_pkt !== held) begin errors++; $display("FAIL stall pkt %0d: got %h want %h", n, dout_pkt, held); end
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_bft);
      dout_ready = 1'b1;
      #1; predict();
      checks++;
      if (ack_user !== exp_ack) begin errors++; $display("FAIL release ack %0d: got %b want %b", n, ack_user, exp_ack); end
      advance();
      checks++;
      if (!pkt_ok()) begin errors++; $display("FAIL release pkt %0d: got %h want %h", n, dout_pkt, m_pkt); end
    end
    @(negedge clk_bft);
    dout_ready = 1'b0; reset_bft = 1'b1;
    #1; predict();
    advance();
    checks++;
    if (dout_pkt !== 49'd0) begin errors++; $display("FAIL stall reset pkt: got %h want 0", dout_pkt); end
    @(negedge clk_bft);
    reset_bft = 1'b0; vld_user = '0; dout_ready = 1'b1;
  endtask

  task automatic test_credit();
    int acks;
    do_reset();
    cfg(0, 1, 1, 1);
    acks = 0;
    for (int n = 0; n < 140; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      vld_user = 4'b0001;
      #1; predict();
      checks++;
      if (ack_user !== exp_ack) begin errors++; $display("FAIL credit ack %0d: got %b want %b", n, ack_user, exp_ack); end
      acks += int'(ack_user[0]);
      advance();
    end
    checks++;
    if (acks != 128) begin errors++; $display("FAIL credit drain: got %0d want 128", acks); end
    checks++;
    if (credit_cnt_dbg[7:0] !== 8'd0) begin errors++; $display("FAIL credit zero: got %0d want 0", credit_cnt_dbg[7:0]); end
    @(negedge clk_bft);
    credit_upd = 4'b0001;
    #1; predict();
    checks++;
    if (ack_user !== 4'b0000) begin errors++; $display("FAIL credit upd same cycle ack: got %b want 0000", ack_user); end
    advance();
    credit_upd = '0;
    acks = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      #1; predict();
      acks += int'(ack_user[0]);
      advance();
      checks++;
      if (!pkt_ok()) begin errors++; $display("FAIL credit pkt %0d: got %h want %h", n, dout_pkt, m_pkt); end
    end
    checks++;
    if (acks != 64) begin errors++; $display("FAIL credit refill: got %0d want 64", acks); end
    @(negedge clk_bft);
    vld_user = '0; credit_upd = 4'b0001;
    #1; predict();
    advance();
    @(negedge clk_bft);
    vld_user = 4'b0001; credit_upd = 4'b0001;
    #1; predict();
    advance();
    checks++;
    if (credit_cnt_dbg[7:0] !== 8'd127) begin errors++; $display("FAIL credit net: got %0d want 127", credit_cnt_dbg[7:0]); end
    @(negedge clk_bft);
    vld_user = '0; credit_upd = 4'b1000;
    #1; predict();
    advance();
    credit_upd = '0;
    checks++;
    if (credit_cnt_dbg[31:24] !== 8'd128) begin errors++; $display("FAIL credit saturate: got %0d want 128", credit_cnt_dbg[31:24]); end
    checks++;
    if (credit_cnt_dbg !== exp_dbg()) begin errors++; $display("FAIL credit dbg: got %h want %h", credit_cnt_dbg, exp_dbg()); end
  endtask

  task automatic test_addr_wrap_config();
    do_reset();
    cfg(2, 1, 9, 6);
    for (int n = 0; n < 130; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      vld_user = 4'b0100; credit_upd = 4'b0100; dout_ready = 1'b1;
      #1; predict();
      advance();
      checks++;
      if (dout_pkt[38:32] !== 7'(n % 128) || dout_pkt[48] !== 1'b1)
        begin errors++; $display("FAIL addr %0d: got %h want addr %0d", n, dout_pkt, n % 128); end
    end
    @(negedge clk_bft);
    credit_upd = '0;
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_en = 1'b1; cfg_leaf = 5'd17; cfg_port = 4'd11;
    #1; predict();
    checks++;
    if (ack_user !== 4'b0100) begin errors++; $display("FAIL cfg grant ack: got %b want 0100", ack_user); end
    advance();
    cfg_we = 1'b0;
    checks++;
    if (dout_pkt[47:39] !== {5'd9, 4'd6}) begin errors++; $display("FAIL cfg old dest: got %h want %h", dout_pkt[47:39], {5'd9, 4'd6}); end
    @(negedge clk_bft);
    #1; predict();
    advance();
    checks++;
    if (dout_pkt[47:39] !== {5'd17, 4'd11}) begin errors++; $display("FAIL cfg new dest: got %h want %h", dout_pkt[47:39], {5'd17, 4'd11}); end
    vld_user = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) cfg(i, int'($urandom_range(3) != 0), $urandom_range(31), $urandom_range(15));
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_bft);
      din_user = {$urandom, $urandom, $urandom, $urandom};
      vld_user = 4'($urandom);
      dout_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) credit_upd[i] = ($urandom_range(15) == 0);
      cfg_we = ($urandom_range(19) == 0);
      cfg_sel = 2'($urandom); cfg_en = ($urandom_range(3) != 0);
      cfg_leaf = 5'($urandom); cfg_port = 4'($urandom);
      #1; predict();
      checks++;
      if (ack_user !== exp_ack) begin errors++; $display("FAIL rand ack %0d: got %b want %b", n, ack_user, exp_ack); end
      advance();
      checks++;
      if (!pkt_ok()) begin errors++; $display("FAIL rand pkt %0d: got %h want %h", n, dout_pkt, m_pkt); end
      checks++;
      if (credit_cnt_dbg !== exp_dbg()) begin errors++; $display("FAIL rand credit %0d: got %h want %h", n, credit_cnt_dbg, exp_dbg()); end
    end
    cfg_we = 1'b0; vld_user = '0; credit_upd = '0;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_back_pressure();
    test_credit();
    test_addr_wrap_config();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/leaf_tx_scheduler.md
# leaf_tx_scheduler

Transmit-side scheduler for a leaf node. It shares the single 49-bit BFT output link among NUM_IN_PORTS user output streams using a round-robin arbiter, with per-stream credit-based flow control. It also builds each packet's header from a per-stream destination table. It sits between the user operator's vld/ack streams and the leaf's BFT output path, entirely in the clk_bft domain.

## Interface
- NUM_IN_PORTS, 4: number of user streams arbitrated.
- PAYLOAD_BITS, 32: payload width per word.
- NUM_LEAF_BITS, 5: destination leaf field width.
- NUM_PORT_BITS, 4: destination port field width.
- NUM_ADDR_BITS, 7: packet address field width (per-stream sequence address).
- CREDIT_INIT, 128: credits per stream after reset (remote buffer depth).
- FREESPACE_UPDATE_SIZE, 64: credits returned per credit_upd pulse.
- PACKET_BITS, 49: equals 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS.

Ports:
- clk_bft  in  1  sole clock.
- reset_bft  in  1  synchronous, active-high reset.
- din_user  in  NUM_IN_PORTS*PAYLOAD_BITS  stream words; stream i occupies slice i.
- vld_user  in  NUM_IN_PORTS  per-stream word valid.
- ack_user  out  NUM_IN_PORTS  per-stream accept; combinational, one-hot or zero.
- credit_upd  in  NUM_IN_PORTS  one-cycle pulse per stream that returns FREESPACE_UPDATE_SIZE credits.
- cfg_we  in  1  destination-table write strobe.
- cfg_sel  in  clog2(NUM_IN_PORTS)  table entry to write.
- cfg_en  in  1  stream-enable bit to write.
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf to write.
- cfg_port  in  NUM_PORT_BITS  destination port to write.
- dout_pkt  out  PACKET_BITS  registered packet: bit 48 is valid, then leaf[47:43], port[42:39], addr[38:32], payload[31:0].
- dout_ready  in  1  downstream accepts dout_pkt this cycle.
- credit_cnt_dbg  out  NUM_IN_PORTS*8  current credit counters, for debug.

## Operation
- **Eligibility.** Stream i is eligible when vld_user[i]=1, its table entry has en=1, and its credit[i] > 0.
- **Load condition.** load = (dout_pkt[48]==0) | dout_ready.
- **Arbitration.** When load=1 and at least one stream is eligible, grant exactly one stream, round-robin.
  - The search starts at rr_ptr+1 and wraps modulo NUM_IN_PORTS.
  - On a grant, rr_ptr takes the granted index.
  - Non-eligible streams are skipped and do not consume a turn.
- **Accept.** ack_user[g]=1 for the granted stream only, in the same cycle. The word is consumed on vld&ack.
- **Packet build (registered).** On grant, the next cycle's dout_pkt = {1, leaf[g], port[g], addr[g], din_user slice g}.
- **Empty output.** If load=1 and no stream is eligible, dout_pkt[48] goes to 0. The other dout_pkt bits are don't-care.
- **Stall.** If load=0, dout_pkt holds all bits unchanged and no ack is issued.
- **Address counter.** addr[g] increments by 1 per sent word and wraps from 2^NUM_ADDR_BITS-1 to 0.
- **Credit counters** (8 bits, unsigned):
  - Decrement by 1 on a grant.
  - Increase by FREESPACE_UPDATE_SIZE on credit_upd.
  - If both happen in one cycle, apply the net +FREESPACE_UPDATE_SIZE-1.
  - The result saturates at CREDIT_INIT; the excess is dropped.
  - Eligibility uses the pre-update count, so a stream at 0 credits with credit_upd this cycle is eligible only from the next cycle.
- **Config write.** cfg_we writes {en, leaf, port} to entry cfg_sel and takes effect from the next cycle's arbitration.
  - A packet already in dout_pkt is not modified.
  - Clearing en does not reset that stream's addr or credit.

## Timing
- **Reset** (reset_bft=1 at a clk_bft edge):
  - dout_pkt = 0; ack_user = 0 (combinationally forced while reset is high).
  - rr_ptr = NUM_IN_PORTS-1, so stream 0 is served first.
  - All table entries = {en=0, leaf=0, port=0}.
  - All addr = 0; all credit = CREDIT_INIT.
  - Reset asserted mid-stall discards the held packet.
- **Latency.** One cycle from the vld&ack cycle to the packet appearing on dout_pkt.
- **Throughput.** One packet per cycle while dout_ready=1.
- **Simultaneous events.** cfg_we and a grant to the same stream in the same cycle: the packet uses the old table entry.

## Test plan
- **Reset values.** Assert reset_bft for 2 cycles → dout_pkt=0, ack_user=0, credit_cnt_dbg shows 128 for every stream.
- **Single stream.** Enable stream 1 with leaf=5, port=3; drive vld_user=0010 and din=0xDEADBEEF with dout_ready=1 for 3 cycles → ack on stream 1 each cycle; dout_pkt = {1,5,3,addr,0xDEADBEEF} with addr 0, 1, 2.
- **Round robin.** Enable all four streams, hold all vld, dout_ready=1 → grant order 0, 1, 2, 3, 0…; each stream receives 2 of 8 packets.
- **Backpressure.** During traffic, drop dout_ready for 4 cycles → dout_pkt constant and ack_user=0 throughout; on release, the held packet leaves and arbitration resumes at the next stream in order.
- **Credit exhaustion.** Send 128 words on stream 0 → credit reaches 0 and ack stops. Pulse credit_upd[0] → 64 more words are accepted. A credit_upd pulse at 128 credits stays at 128 (saturation).
- **Address wrap and config.** Send 130 words on one stream with credits replenished → addr goes 127 then 0, 1. A cfg_we on the same cycle as a grant → that packet carries the old leaf/port and the next packet carries the new values.
